alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 OP_CODE  input  14  PIC16F84-format instruction word; decode uses OP_CODE[13:7] only.
REQ-005 L_REG  input  8  literal operand k for literal instructions.
REQ-006 REG1  input  8  file-register operand f.
REQ-007 d  input  1  destination select for byte-oriented file ops: 0 = W_REG, 1 = FSR_REG.
REQ-008 b  input  3  bit index for BCF/BSF.
REQ-009 W_REG  output  8  working register, registered.
REQ-010 FSR_REG  output  8  file-result register, holds last value written to destination F, registered.
REQ-011 STATUS_REG  output  8  status flags, registered: bit0 C, bit1 DC, bit2 Z, bits7:3 always 0.

Function
REQ-012 All outputs SHALL update only on rising clk, one-cycle latency: operands sampled at edge N, result visible after edge N.
REQ-013 OP_CODE SHALL be re-executed every cycle it is held, using the current W_REG (e.g. repeated ADDLW accumulates).
REQ-014 Decode on OP_CODE[13:8]: 000111 ADDWF, 000101 ANDWF, 001001 COMF, 000011 DECF, 001010 INCF, 000100 IORWF, 001000 MOVF, 001101 RLF, 001100 RRF, 000010 SUBWF, 001110 SWAPF, 000110 XORWF.
REQ-015 OP_CODE[13:8]=000001: bit7=1 CLRF, bit7=0 CLRW; 000000: bit7=1 MOVWF, bit7=0 NOP.
REQ-016 OP_CODE[13:10]: 0100 BCF, 0101 BSF; 0110/0111 (BTFSC/BTFSS) SHALL act as NOP.
REQ-017 Literal ops: [13:10]=1100 MOVLW, [13:9]=11111 ADDLW, [13:9]=11110 SUBLW, [13:8]=111001 ANDLW, 111000 IORLW, 111010 XORLW; any other code SHALL act as NOP.
REQ-018 Byte-oriented file-op result: d=0 -> W_REG, d=1 -> FSR_REG; non-selected register holds.
REQ-019 Results: ADDWF f+W; ANDWF f&W; IORWF f|W; XORWF f^W; SUBWF f-W; COMF ~f; DECF f-1; INCF f+1; MOVF f; SWAPF {f[3:0],f[7:4]}; RLF {f[6:0],C}, new C=f[7]; RRF {C,f[7:1]}, new C=f[0].
REQ-020 CLRF: FSR_REG=0, Z=1; CLRW: W_REG=0, Z=1; MOVWF: FSR_REG=W_REG, no flags.
REQ-021 BCF/BSF: FSR_REG = REG1 with bit b cleared/set; W_REG and flags unchanged.
REQ-022 Literals: MOVLW W=k; ADDLW W=k+W; SUBLW W=k-W; ANDLW/IORLW/XORLW W=k op W; MOVLW affects no flags.
REQ-023 Arithmetic 8-bit modulo 256; add: C = carry out of bit7, DC = carry out of bit3.
REQ-024 Subtract (SUBWF, SUBLW) via two's-complement add: C=1 no borrow (minuend >= W), DC=1 no nibble borrow.
REQ-025 Z = (8-bit result == 0) for ADDWF, ANDWF, COMF, DECF, INCF, IORWF, MOVF, SUBWF, XORWF and all literal ops except MOVLW.
REQ-026 C,DC affected only by ADD*/SUB*; C also by RLF/RRF; unaffected flags SHALL hold value.
REQ-027 NOP SHALL hold W_REG, FSR_REG, STATUS_REG.

Reset
REQ-028 rst_n low SHALL immediately clear W_REG, FSR_REG, STATUS_REG to 8'h00, regardless of clk.
REQ-029 Reset assertion mid-operation SHALL discard the in-flight result; first edge after rst_n high executes the current OP_CODE normally.

Verification
REQ-030 Reset: rst_n=0 for any inputs -> W_REG=00, FSR_REG=00, STATUS_REG=00.
REQ-031 MOVLW k=03, then ADDLW k=19 one cycle -> W_REG=1C, C=0, DC=0, Z=0; second ADDLW cycle -> W_REG=35, DC=1.
REQ-032 W=01, ADDLW k=FF -> W_REG=00, STATUS_REG=00000111; then SUBLW k=02 with W=03 -> W_REG=FF, C=0, Z=0.
REQ-033 W=00, REG1=F0, ADDWF d=1 -> FSR_REG=F0, W_REG=00, Z=0, C=0; ANDWF d=0 -> W_REG=00, Z=1.
REQ-034 C=0, REG1=80, RLF d=0 -> W_REG=00, C=1, Z unchanged; then RRF REG1=00 d=0 -> W_REG=80, C=0.
REQ-035 REG1=00, BSF b=2 -> FSR_REG=04, flags unchanged; REG1=FF, BCF b=7 -> FSR_REG=7F; SWAPF REG1=A5 d=0 -> W_REG=5A.

Source files
------------

// File: rtl/alu.sv
// PIC16F84-style ALU: decodes one instruction per cycle against W and an
// external file operand, updating W, a file-result register and C/DC/Z flags.
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] OP_CODE,
  input  logic [7:0]  L_REG,
  input  logic [7:0]  REG1,
  input  logic        d,
  input  logic [2:0]  b,
  output logic [7:0]  W_REG,
  output logic [7:0]  FSR_REG,
  output logic [7:0]  STATUS_REG
);

  typedef enum logic [4:0] {
    OP_NOP,   OP_ADDWF, OP_ANDWF, OP_COMF,  OP_DECF,  OP_INCF,
    OP_IORWF, OP_MOVF,  OP_RLF,   OP_RRF,   OP_SUBWF, OP_SWAPF,
    OP_XORWF, OP_CLRF,  OP_CLRW,  OP_MOVWF, OP_BCF,   OP_BSF,
    OP_MOVLW, OP_ADDLW, OP_SUBLW, OP_ANDLW, OP_IORLW, OP_XORLW
  } op_e;

  logic [7:0] r_w;
  logic [7:0] r_fsr;
  logic       r_c;
  logic       r_dc;
  logic       r_z;

  op_e        w_op;
  logic [7:0] w_res;
  logic       w_c_nxt;
  logic       w_dc_nxt;
  logic       w_z_nxt;
  logic       w_upd_z;
  logic       w_file;
  logic       w_wr_w;
  logic       w_wr_f;
  logic       w_unused_ok;

  // Returns {carry out of bit 7, carry out of bit 3, 8-bit sum}.
  function automatic logic [9:0] add8(input logic [7:0] a, input logic [7:0] x,
                                      input logic cin);
    logic [8:0] full;
    logic [4:0] nib;
    full = {1'b0, a} + {1'b0, x} + {8'b0, cin};
    nib  = {1'b0, a[3:0]} + {1'b0, x[3:0]} + {4'b0, cin};
    return {full[8], nib[4], full[7:0]};
  endfunction

  // Subtraction as a + ~x + 1, so carry-out doubles as "no borrow".
  function automatic logic [9:0] sub8(input logic [7:0] a, input logic [7:0] x);
    return add8(a, ~x, 1'b1);
  endfunction

  function automatic logic [7:0] bitop(input logic [7:0] v, input logic [2:0] idx,
                                       input logic set);
    logic [7:0] r;
    r      = v;
    r[idx] = set;
    return r;
  endfunction

  // Only the upper seven opcode bits take part in decode.
  assign w_unused_ok = ^OP_CODE[6:0];

  always_comb begin
    w_op = OP_NOP;
    casez (OP_CODE[13:8])
      6'b000111: w_op = OP_ADDWF;
      6'b000101: w_op = OP_ANDWF;
      6'b001001: w_op = OP_COMF;
      6'b000011: w_op = OP_DECF;
      6'b001010: w_op = OP_INCF;
      6'b000100: w_op = OP_IORWF;
      6'b001000: w_op = OP_MOVF;
      6'b001101: w_op = OP_RLF;
      6'b001100: w_op = OP_RRF;
      6'b000010: w_op = OP_SUBWF;
      6'b001110: w_op = OP_SWAPF;
      6'b000110: w_op = OP_XORWF;
      6'b000001: w_op = OP_CODE[7] ? OP_CLRF : OP_CLRW;
      6'b000000: w_op = OP_CODE[7] ? OP_MOVWF : OP_NOP;
      6'b0100??: w_op = OP_BCF;
      6'b0101??: w_op = OP_BSF;
      6'b1100??: w_op = OP_MOVLW;
      6'b11111?: w_op = OP_ADDLW;
      6'b11110?: w_op = OP_SUBLW;
      6'b111001: w_op = OP_ANDLW;
      6'b111000: w_op = OP_IORLW;
      6'b111010: w_op = OP_XORLW;
      default:   w_op = OP_NOP;
    endcase
  end

  always_comb begin
    w_res    = r_w;
    w_c_nxt  = r_c;
    w_dc_nxt = r_dc;
    w_z_nxt  = r_z;
    w_upd_z  = 1'b0;
    w_file   = 1'b0;
    w_wr_w   = 1'b0;
    w_wr_f   = 1'b0;
    case (w_op)
      OP_ADDWF: begin {w_c_nxt, w_dc_nxt, w_res} = add8(REG1, r_w, 1'b0); w_upd_z = 1'b1; w_file = 1'b1; end
      OP_SUBWF: begin {w_c_nxt, w_dc_nxt, w_res} = sub8(REG1, r_w);       w_upd_z = 1'b1; w_file = 1'b1; end
      OP_ANDWF: begin w_res = REG1 & r_w;   w_upd_z = 1'b1; w_file = 1'b1; end
      OP_IORWF: begin w_res = REG1 | r_w;   w_upd_z = 1'b1; w_file = 1'b1; end
      OP_XORWF: begin w_res = REG1 ^ r_w;   w_upd_z = 1'b1; w_file = 1'b1; end
      OP_COMF:  begin w_res = ~REG1;        w_upd_z = 1'b1; w_file = 1'b1; end
      OP_DECF:  begin w_res = REG1 - 8'd1;  w_upd_z = 1'b1; w_file = 1'b1; end
      OP_INCF:  begin w_res = REG1 + 8'd1;  w_upd_z = 1'b1; w_file = 1'b1; end
      OP_MOVF:  begin w_res = REG1;         w_upd_z = 1'b1; w_file = 1'b1; end
      OP_SWAPF: begin w_res = {REG1[3:0], REG1[7:4]}; w_file = 1'b1; end
      // Rotates go through the carry flag; Z is left alone.
      OP_RLF:   begin w_res = {REG1[6:0], r_c}; w_c_nxt = REG1[7]; w_file = 1'b1; end
      OP_RRF:   begin w_res = {r_c, REG1[7:1]}; w_c_nxt = REG1[0]; w_file = 1'b1; end
      OP_CLRF:  begin w_res = 8'h00; w_upd_z = 1'b1; w_wr_f = 1'b1; end
      OP_CLRW:  begin w_res = 8'h00; w_upd_z = 1'b1; w_wr_w = 1'b1; end
      OP_MOVWF: begin w_res = r_w;   w_wr_f = 1'b1; end
      OP_BCF:   begin w_res = bitop(REG1, b, 1'b0); w_wr_f = 1'b1; end
      OP_BSF:   begin w_res = bitop(REG1, b, 1'b1); w_wr_f = 1'b1; end
      OP_MOVLW: begin w_res = L_REG; w_wr_w = 1'b1; end
      OP_ADDLW: begin {w_c_nxt, w_dc_nxt, w_res} = add8(L_REG, r_w, 1'b0); w_upd_z = 1'b1; w_wr_w = 1'b1; end
      OP_SUBLW: begin {w_c_nxt, w_dc_nxt, w_res} = sub8(L_REG, r_w);       w_upd_z = 1'b1; w_wr_w = 1'b1; end
      OP_ANDLW: begin w_res = L_REG & r_w; w_upd_z = 1'b1; w_wr_w = 1'b1; end
      OP_IORLW: begin w_res = L_REG | r_w; w_upd_z = 1'b1; w_wr_w = 1'b1; end
      OP_XORLW: begin w_res = L_REG ^ r_w; w_upd_z = 1'b1; w_wr_w = 1'b1; end
      default:  begin w_res = r_w; end
    endcase
    if (w_upd_z) w_z_nxt = (w_res == 8'h00);
    if (w_file) begin
      w_wr_w = ~d;
      w_wr_f = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w   <= 8'h00;
      r_fsr <= 8'h00;
      r_c   <= 1'b0;
      r_dc  <= 1'b0;
      r_z   <= 1'b0;
    end else begin
      if (w_wr_w) r_w   <= w_res;
      if (w_wr_f) r_fsr <= w_res;
      r_c  <= w_c_nxt;
      r_dc <= w_dc_nxt;
      r_z  <= w_z_nxt;
    end
  end

  assign W_REG      = r_w;
  assign FSR_REG    = r_fsr;
  assign STATUS_REG = {5'b00000, r_z, r_dc, r_c};

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the ALU; each check compares {W, FSR, STATUS}.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [13:0] OP_CODE;
  logic [7:0]  L_REG;
  logic [7:0]  REG1;
  logic        d;
  logic [2:0]  b;
  logic [7:0]  W_REG;
  logic [7:0]  FSR_REG;
  logic [7:0]  STATUS_REG;

  int checks = 0;
  int errors = 0;

  alu dut (
    .clk(clk), .rst_n(rst_n), .OP_CODE(OP_CODE), .L_REG(L_REG), .REG1(REG1),
    .d(d), .b(b), .W_REG(W_REG), .FSR_REG(FSR_REG), .STATUS_REG(STATUS_REG)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive at posedge+1, then sample 1 time unit after the next rising edge.
  task automatic exec(input logic [13:0] op, input logic [7:0] l, input logic [7:0] r,
                      input logic dd, input logic [2:0] bb);
    OP_CODE = op; L_REG = l; REG1 = r; d = dd; b = bb;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [23:0] got;
    OP_CODE = 14'h3E00; L_REG = 8'hFF; REG1 = 8'hFF; d = 1'b1; b = 3'd7;
    rst_n = 1'b0;
    #3;
    got = {W_REG, FSR_REG, STATUS_REG};
    checks++;
    if (got !== 24'h000000) begin errors++; $display("FAIL reset_async got %h exp %h", got, 24'h000000); end
    @(posedge clk); #1;
    got = {W_REG, FSR_REG, STATUS_REG};
    checks++;
    if (got !== 24'h000000) begin errors++; $display("FAIL reset_held got %h exp %h", got, 24'h000000); end
    OP_CODE = 14'h0000;
    rst_n = 1'b1;
    @(posedge clk); #1;
    got = {W_REG, FSR_REG, STATUS_REG};
    checks++;
    if (got !== 24'h000000) begin errors++; $display("FAIL reset_release got %h exp %h", got, 24'h000000); end
  endtask

  task automatic test_literal();
    logic [13:0] ops [12] = '{14'h3000, 14'h3E00, 14'h3E00, 14'h3000, 14'h3E00, 14'h3000,
                              14'h3C00, 14'h3C00, 14'h3800, 14'h3A00, 14'h3900, 14'h3C00};
    logic [7:0]  lit [12] = '{8'h03, 8'h19, 8'h19, 8'h01, 8'hFF, 8'h03,
                              8'h02, 8'h05, 8'hF0, 8'hF6, 8'h55, 8'h00};
    logic [23:0] exp [12] = '{24'h030000, 24'h1C0000, 24'h350002, 24'h010002,
                              24'h000007, 24'h030007, 24'hFF0000, 24'h060000,
                              24'hF60000, 24'h000004, 24'h000004, 24'h000007};
    logic [23:0] got;
    for (int i = 0; i < 12; i++) begin
      exec(ops[i], lit[i], 8'hAA, 1'b1, 3'd5);
      got = {W_REG, FSR_REG, STATUS_REG};
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL literal[%0d] op %h got %h exp %h", i, ops[i], got, exp[i]);
      end
    end
  endtask

  task automatic test_file_ops();
    logic [13:0] ops [18] = '{14'h0100, 14'h0700, 14'h0500, 14'h0D00, 14'h0C00, 14'h0200,
                              14'h0900, 14'h0A00, 14'h0300, 14'h0800, 14'h0400, 14'h0600,
                              14'h0080, 14'h0180, 14'h0E00, 14'h0700, 14'h0C00, 14'h0D00};
    logic [7:0]  rv  [18] = '{8'h00, 8'hF0, 8'hF0, 8'h80, 8'h00, 8'h80,
                              8'h00, 8'hFF, 8'h00, 8'h00, 8'h3C, 8'h3C,
                              8'h00, 8'h00, 8'hA5, 8'h08, 8'h01, 8'h01};
    logic        dv  [18] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                              1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [23:0] exp [18] = '{24'h000007, 24'h00F000, 24'h00F004, 24'h00F005,
                              24'h80F004, 24'h800007, 24'h80FF03, 24'h00FF07,
                              24'h00FF03, 24'h000007, 24'h3C0003, 24'h3C0007,
                              24'h3C3C07, 24'h3C0007, 24'h5A0007, 24'h620002,
                              24'h620003, 24'h620302};
    logic [23:0] got;
    for (int i = 0; i < 18; i++) begin
      exec(ops[i], 8'h99, rv[i], dv[i], 3'd1);
      got = {W_REG, FSR_REG, STATUS_REG};
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL file[%0d] op %h got %h exp %h", i, ops[i], got, exp[i]);
      end
    end
  endtask

  task automatic test_bit_ops();
    logic [13:0] ops [4] = '{14'h1400, 14'h1000, 14'h1000, 14'h1400};
    logic [7:0]  rv  [4] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
    logic [2:0]  bv  [4] = '{3'd2, 3'd7, 3'd0, 3'd7};
    logic [23:0] exp [4] = '{24'h620402, 24'h627F02, 24'h62FE02, 24'h628002};
    logic [23:0] got;
    for (int i = 0; i < 4; i++) begin
      exec(ops[i], 8'h11, rv[i], 1'b0, bv[i]);
      got = {W_REG, FSR_REG, STATUS_REG};
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL bit[%0d] op %h got %h exp %h", i, ops[i], got, exp[i]);
      end
    end
  endtask

  task automatic test_nop_hold();
    logic [13:0] ops [7] = '{14'h0000, 14'h1800, 14'h1C00, 14'h3B00, 14'h0B00, 14'h2000, 14'h0F00};
    logic [23:0] got;
    for (int i = 0; i < 7; i++) begin
      exec(ops[i], 8'h77, 8'h55, i[0], 3'd3);
      got = {W_REG, FSR_REG, STATUS_REG};
      checks++;
      if (got !== 24'h628002) begin
        errors++;
        $display("FAIL hold[%0d] op %h got %h exp %h", i, ops[i], got, 24'h628002);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] got;
    exec(14'h3E00, 8'h05, 8'h00, 1'b0, 3'd0);
    got = {W_REG, FSR_REG, STATUS_REG};
    checks++;
    if (got !== 24'h678000) begin errors++; $display("FAIL mid_pre got %h exp %h", got, 24'h678000); end
    #2 rst_n = 1'b0;
    #1;
    got = {W_REG, FSR_REG, STATUS_REG};
    checks++;
    if (got !== 24'h000000) begin errors++; $display("FAIL mid_async got %h exp %h", got, 24'h000000); end
    @(posedge clk); #1;
    got = {W_REG, FSR_REG, STATUS_REG};
    checks++;
    if (got !== 24'h000000) begin errors++; $display("FAIL mid_held got %h exp %h", got, 24'h000000); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    got = {W_REG, FSR_REG, STATUS_REG};
    checks++;
    if (got !== 24'h050000) begin errors++; $display("FAIL mid_first got %h exp %h", got, 24'h050000); end
    @(posedge clk); #1;
    got = {W_REG, FSR_REG, STATUS_REG};
    checks++;
    if (got !== 24'h0A0000) begin errors++; $display("FAIL mid_second got %h exp %h", got, 24'h0A0000); end
  endtask

  initial begin
    rst_n = 1'b0; OP_CODE = 14'h0000; L_REG = 8'h00; REG1 = 8'h00; d = 1'b0; b = 3'd0;
    test_reset();
    test_literal();
    test_file_ops();
    test_bit_ops();
    test_nop_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
